// File: rtl/tgl_hs_responder.sv
// -----------------------------------------------------------------------------
// tgl_hs_responder
//
// Responder end of a two-phase toggle handshake. Every level change of
// req_tgl is one request. The request line is synchronised, each flip is
// detected as a one-cycle edge, the payload is captured with a one-cycle
// strobe, and ack_tgl is flipped ACK_DLY cycles after the capture.
//
// Parameters
//   SYNC_STAGES  flops in the req_tgl synchroniser (2..4)
//   DW           payload width
//   ACK_DLY      cycles from capture to the ack_tgl flip (1..15)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   req_tgl   request toggle from the initiator
//   data_in   payload, sampled only at the capture edge
//   ack_tgl   acknowledge toggle, flips once per accepted request
//   pulse     one-cycle strobe on capture
//   data_out  captured payload
//   data_vld  high from the first capture until reset
//   busy      high while the FSM is in HOLD (doubles as the FSM state view)
//   evt_cnt   accepted-request count, wraps 255->0
//   ovr       sticky overrun flag
//
// Handshake: a request is posted by flipping req_tgl with data_in already
// stable; it is acknowledged by the ack_tgl flip, after which the initiator
// may change data_in and flip again. An edge seen while in HOLD is dropped.
//
// Configuration macro: TGL_HS_OVR_DET_EN
//   defined   - an edge detected in HOLD sets ovr until reset
//   undefined - ovr is tied to 0 and no overrun logic exists
// -----------------------------------------------------------------------------
module tgl_hs_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int DW          = 8,
   parameter int ACK_DLY     = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_tgl,
   input  logic [DW-1:0] data_in,
   output logic          ack_tgl,
   output logic          pulse,
   output logic [DW-1:0] data_out,
   output logic          data_vld,
   output logic          busy,
   output logic [7:0]    evt_cnt,
   output logic          ovr
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_INIT = 4'(ACK_DLY);

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_req_d;
   logic [3:0]             r_hold_cnt;
   logic                   r_ack;
   logic                   r_pulse;
   logic [DW-1:0]          r_data;
   logic                   r_vld;
   logic [7:0]             r_evt_cnt;
`ifdef TGL_HS_OVR_DET_EN
   logic                   r_ovr;
`endif

   logic w_req_s;
   logic w_edge;

   // Last synchroniser stage is the usable request level; an edge is any
   // difference between it and its one-cycle-delayed copy.
   assign w_req_s = r_sync[SYNC_STAGES-1];
   assign w_edge  = w_req_s ^ r_req_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync  <= '0;
         r_req_d <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], req_tgl};
         r_req_d <= w_req_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= 4'd0;
         r_ack      <= 1'b0;
         r_pulse    <= 1'b0;
         r_data     <= '0;
         r_vld      <= 1'b0;
         r_evt_cnt  <= 8'd0;
`ifdef TGL_HS_OVR_DET_EN
         r_ovr      <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pulse <= 1'b0;
               if (w_edge) begin
                  r_data     <= data_in;
                  r_pulse    <= 1'b1;
                  r_vld      <= 1'b1;
                  r_evt_cnt  <= r_evt_cnt + 8'd1;
                  r_hold_cnt <= HOLD_INIT;
                  r_state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               r_pulse <= 1'b0;
               // The count reaching zero on this edge is the ack edge, so the
               // flip happens while the counter still reads one.
               if (r_hold_cnt == 4'd1) begin
                  r_hold_cnt <= 4'd0;
                  r_ack      <= ~r_ack;
                  r_state    <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 4'd1;
               end
`ifdef TGL_HS_OVR_DET_EN
               // An edge here is dropped; only the sticky flag records it.
               if (w_edge) begin
                  r_ovr <= 1'b1;
               end
`endif
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack_tgl  = r_ack;
   assign pulse    = r_pulse;
   assign data_out = r_data;
   assign data_vld = r_vld;
   assign busy     = (r_state == ST_HOLD);
   assign evt_cnt  = r_evt_cnt;
`ifdef TGL_HS_OVR_DET_EN
   assign ovr      = r_ovr;
`else
   assign ovr      = 1'b0;
`endif

endmodule

// File: tb/tb_tgl_hs_responder.sv
// Testbench for tgl_hs_responder. The reference model works at transaction
// level: each req_tgl flip becomes a detection time (flip edge + SYNC_STAGES);
// a detection is accepted when it falls at or after the ready time of the
// previous accepted request, and an accepted request schedules its ack flip.
module tb_tgl_hs_responder;
  localparam int SS = 2;
  localparam int DW = 8;
  localparam int AD = 2;
`ifdef TGL_HS_OVR_DET_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_tgl = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ack_tgl;
  logic          pulse;
  logic [DW-1:0] data_out;
  logic          data_vld;
  logic          busy;
  logic [7:0]    evt_cnt;
  logic          ovr;

  always #6 clk = ~clk;

  tgl_hs_responder #(
    .SYNC_STAGES (SS),
    .DW          (DW),
    .ACK_DLY     (AD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_tgl  (req_tgl),
    .data_in  (data_in),
    .ack_tgl  (ack_tgl),
    .pulse    (pulse),
    .data_out (data_out),
    .data_vld (data_vld),
    .busy     (busy),
    .evt_cnt  (evt_cnt),
    .ovr      (ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int            cyc = 0;
  int            det_q[$];
  int            ready_cyc = 0;
  int            ack_due = -1;
  logic          last_req = 1'b0;
  logic          m_pulse = 1'b0;
  logic          m_ack = 1'b0;
  logic          m_vld = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [7:0]    m_cnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    det_q.delete();
    ready_cyc = 0;
    ack_due   = -1;
    last_req  = 1'b0;
    m_pulse   = 1'b0;
    m_ack     = 1'b0;
    m_vld     = 1'b0;
    m_busy    = 1'b0;
    m_ovr     = 1'b0;
    m_data    = '0;
    m_cnt     = '0;
  endtask

  // Model update for the clock edge numbered cyc.
  task automatic model_edge();
    m_pulse = 1'b0;
    if (cyc == ack_due) begin
      m_ack  = ~m_ack;
      m_busy = 1'b0;
    end
    if (det_q.size() > 0 && det_q[0] == cyc) begin
      void'(det_q.pop_front());
      if (cyc >= ready_cyc) begin
        m_data    = data_in;
        m_pulse   = 1'b1;
        m_vld     = 1'b1;
        m_busy    = 1'b1;
        m_cnt     = m_cnt + 8'd1;
        ack_due   = cyc + AD;
        ready_cyc = cyc + AD + 1;
      end else if (OVR_EN) begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("pulse",    32'(pulse),    32'(m_pulse));
    check_eq("ack_tgl",  32'(ack_tgl),  32'(m_ack));
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("data_vld", 32'(data_vld), 32'(m_vld));
    check_eq("busy",     32'(busy),     32'(m_busy));
    check_eq("evt_cnt",  32'(evt_cnt),  32'(m_cnt));
    check_eq("ovr",      32'(ovr),      32'(m_ovr));
  endtask

  // driver: one clock cycle; inputs change on the falling edge
  task automatic do_cycle(input bit flip, input bit chg, input logic [DW-1:0] d, input bit rst_n_v);
    @(negedge clk);
    rst = rst_n_v;
    if (!rst_n_v) model_reset();
    if (chg) data_in = d;
    if (flip) req_tgl = ~req_tgl;
    if (rst_n_v && (req_tgl != last_req)) begin
      det_q.push_back(cyc + SS);
      last_req = req_tgl;
    end
    @(posedge clk);
    if (rst_n_v) model_edge();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  // reset for n cycles, with the initiator toggle brought back to 0
  task automatic reset_cycles(input int n);
    do_cycle(req_tgl, 1'b0, '0, 1'b0);
    for (int i = 1; i < n; i++) do_cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    // 1. reset with activity on inputs
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    check_eq("s1_ack",  32'(ack_tgl), 32'd0);
    check_eq("s1_busy", 32'(busy),    32'd0);
    idle(5);
    check_eq("s1_cnt", 32'(evt_cnt), 32'd0);

    // 2. single request; pulse expected two edges after the flip is sampled
    do_cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    idle(1);
    check_eq("s2_nopulse_early", 32'(pulse), 32'd0);
    idle(1);
    check_eq("s2_pulse", 32'(pulse), 32'd1);
    idle(2);
    check_eq("s2_ack",  32'(ack_tgl),  32'd1);
    check_eq("s2_data", 32'(data_out), 32'hA5);
    check_eq("s2_cnt",  32'(evt_cnt),  32'd1);
    idle(2);

    // 3. second request
    do_cycle(1'b1, 1'b1, 8'h3C, 1'b1);
    idle(6);
    check_eq("s3_data", 32'(data_out), 32'h3C);
    check_eq("s3_ack",  32'(ack_tgl),  32'd0);
    check_eq("s3_cnt",  32'(evt_cnt),  32'd2);

    // 4. overrun: two flips one cycle apart
    do_cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    do_cycle(1'b1, 1'b1, 8'hC3, 1'b1);
    idle(8);
    check_eq("s4_cnt", 32'(evt_cnt), 32'd3);
    check_eq("s4_ack", 32'(ack_tgl), 32'd1);
    check_eq("s4_ovr", 32'(ovr),     32'(OVR_EN));
    do_cycle(1'b1, 1'b1, 8'h11, 1'b1);
    idle(6);
    check_eq("s4_ovr_sticky", 32'(ovr), 32'(OVR_EN));

    // 5. reset one cycle after the capture pulse
    do_cycle(1'b1, 1'b1, 8'h77, 1'b1);
    idle(2);
    check_eq("s5_pulse", 32'(pulse), 32'd1);
    idle(1);
    reset_cycles(3);
    check_eq("s5_ack",  32'(ack_tgl), 32'd0);
    check_eq("s5_busy", 32'(busy),    32'd0);
    check_eq("s5_cnt",  32'(evt_cnt), 32'd0);
    idle(8);
    check_eq("s5_ack_after", 32'(ack_tgl), 32'd0);

    // 6. wrap after 256 well-formed requests
    reset_cycles(2);
    for (int i = 0; i < 256; i++) begin
      do_cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      idle(5);
      if (i == 254) check_eq("s6_cnt_255", 32'(evt_cnt), 32'd255);
    end
    check_eq("s6_cnt", 32'(evt_cnt), 32'd0);
    check_eq("s6_ack", 32'(ack_tgl), 32'd0);
    check_eq("s6_ovr", 32'(ovr),     32'd0);

    // 7. random traffic: legal and illegal flips, stray data changes, resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        for (int k = 0; k < 2; k++) do_cycle($urandom_range(0, 1) == 1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      end else begin
        do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), 1'b1);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
